vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator that supersedes the fixed 640x480 timing logic in top. It generates the pixel-clock enable from the single system clock (no separate derived clock), and produces horizontal/vertical counters, sync, data-enable and frame/line strobes. Sync polarity, resolution and divide ratio are set by parameters. Sync/DE outputs can be delayed in pixel ticks to line up with a downstream pixel pipeline of known latency. Sits between the clock/reset source and the pixel renderer that drives VGA_R/G/B.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hs (0 = active-low)
VS_POL, 0, asserted level of vs
CLK_DIV, 2, clk cycles per pixel (>=1; 2 gives 25 MHz from 50 MHz)
PIPE_DLY, 0, pixel-tick delay applied to hs/vs/de (0..15)
FRAME_W, 16, width of frame counter

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous active-high reset
run  in  1  1 = generate timing; 0 = hold idle
pix_en  out  1  one-clk pulse per pixel tick
x  out  clog2(H_TOTAL)  current horizontal count
y  out  clog2(V_TOTAL)  current vertical count
de  out  1  active-video flag (delayed by PIPE_DLY)
hs  out  1  horizontal sync (delayed by PIPE_DLY)
vs  out  1  vertical sync (delayed by PIPE_DLY)
line_start  out  1  pulse on the pix_en where x becomes 0
frame_start  out  1  pulse on the pix_en where x=0 and y becomes 0
frame_cnt  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- Clock/reset: single clock domain. Reset is asynchronous and active-high; all state clears immediately on rst assertion.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Reset values:
  - div_cnt=0, x=0, y=0, pix_en=0, de=0, line_start=0, frame_start=0, frame_cnt=0.
  - hs=~HS_POL, vs=~VS_POL; delay-line contents are set to these idle values.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while run=1.
  - pix_en=1 for exactly one clk when div_cnt==CLK_DIV-1.
  - CLK_DIV=1 gives pix_en held high continuously.
- Counters (advance only on pix_en):
  - x increments; at x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 with x wrapping, y wraps to 0 and frame_cnt increments.
- Raw decode (combinational on x,y):
  - de_raw = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - hs_raw is asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; vs is line-aligned and changes with x wrap.
- Output timing:
  - hs/vs/de are registered, so the raw decode appears on the clk after the counter update.
  - They are then shifted through a PIPE_DLY-deep delay line that advances on pix_en only.
  - x/y are not delayed.
- Strobes: line_start and frame_start are single-clk pulses coincident with pix_en when x (resp. x and y) transition to 0.
- run=0:
  - Synchronously clears div_cnt, x and y; pix_en and strobes are held 0.
  - hs/vs are forced idle and de is forced 0; the delay line is flushed to idle.
  - frame_cnt is retained.
  - On run 0->1, the first pix_en occurs CLK_DIV clks later and moves x from 0 to 1. The first frame does not raise frame_start; frame_start first fires at the next wrap.
- Mid-frame reset: immediate return to reset values. No partial-frame strobes are generated.
- Elaboration: generate an $error if CLK_DIV<1, any porch/sync parameter is <1, or PIPE_DLY>15.

Decomposition:
- Package vga_pkg holds:
  - the timing parameter struct (active/fp/sync/bp per axis);
  - constants for 640x480@60 and 800x600@72;
  - the totals-computation function.
- Sub-module vga_axis_counter: a wrap counter with enable, terminal-count output and a parametrised TOTAL. It is instantiated twice (h, v), with v enabled by h terminal count ANDed with pix_en.

Test Plan:
Small configuration for all scenarios: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), CLK_DIV=2, PIPE_DLY=0, polarities 0.
1. Reset then run=1 -> pix_en every 2nd clk; x counts 0..15 and wraps; line_start at x=0; y=1 after 16 pix_en; frame_cnt=1 after 128 pix_en with one frame_start.
2. Sync decode -> hs low exactly for x=10..12 (3 ticks/line), de high for x=0..7 and y=0..3 only, vs low for y=5..6 (32 pix_en).
3. PIPE_DLY=3 -> hs/vs/de edges lag the PIPE_DLY=0 waveform by exactly 3 pix_en ticks (6 clks); x/y are unchanged.
4. CLK_DIV=1 -> pix_en constantly 1; one full frame = 128 clks; frame_cnt=1.
5. Assert rst asynchronously mid-line (x=5, y=2, between clk edges) -> all outputs at reset values before the next clk edge; after release, counting restarts at x=0, y=0.
6. Drop run at x=9, y=3 for 10 clks, then reassert -> hs=1, vs=1, de=0, no pulses while low; frame_cnt is retained; the first pix_en is 2 clks after run returns.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing types, standard video modes and helpers for vga_timing_gen.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    localparam axis_timing_t VGA_640X480_60_H = '{active: 640, fp: 16, sync: 96, bp: 48};
    localparam axis_timing_t VGA_640X480_60_V = '{active: 480, fp: 10, sync: 2, bp: 33};
    localparam axis_timing_t VGA_800X600_72_H = '{active: 800, fp: 56, sync: 120, bp: 64};
    localparam axis_timing_t VGA_800X600_72_V = '{active: 600, fp: 37, sync: 6, bp: 23};

    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; tc_c flags the last count of the axis.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc_c
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    assign tc_c = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel-tick divider, h/v counters, sync/DE decode
// with a pixel-tick aligned delay line, line/frame strobes and a completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60_H.active,
    parameter int unsigned H_FP     = VGA_640X480_60_H.fp,
    parameter int unsigned H_SYNC   = VGA_640X480_60_H.sync,
    parameter int unsigned H_BP     = VGA_640X480_60_H.bp,
    parameter int unsigned V_ACTIVE = VGA_640X480_60_V.active,
    parameter int unsigned V_FP     = VGA_640X480_60_V.fp,
    parameter int unsigned V_SYNC   = VGA_640X480_60_V.sync,
    parameter int unsigned V_BP     = VGA_640X480_60_V.bp,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned PIPE_DLY = 0,
    parameter int unsigned FRAME_W  = 16,
    localparam axis_timing_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP},
    localparam axis_timing_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP},
    localparam int unsigned  H_TOTAL  = axis_total(H_TIMING),
    localparam int unsigned  V_TOTAL  = axis_total(V_TIMING),
    localparam int unsigned  X_W      = $clog2(H_TOTAL),
    localparam int unsigned  Y_W      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               pix_en,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               de,
    output logic               hs,
    output logic               vs,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam sync_t            SYNC_IDLE = '{de: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

    if (CLK_DIV < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1 || PIPE_DLY > 15) begin : g_param_check
        $error("vga_timing_gen: illegal timing parameter set");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;
    logic             h_tc_c;
    logic             v_tc_c;
    logic             v_en_c;
    sync_t            raw_c;
    sync_t            pipe [0:PIPE_DLY];

    // One pixel tick every CLK_DIV clocks; the counters and strobes all move on this tick.
    assign tick_c = run && (div_cnt == DIV_LAST);
    assign v_en_c = tick_c && h_tc_c;

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .W     (X_W)
    ) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (~run),
        .en   (tick_c),
        .cnt  (x),
        .tc_c (h_tc_c)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .W     (Y_W)
    ) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (~run),
        .en   (v_en_c),
        .cnt  (y),
        .tc_c (v_tc_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            pix_en      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_en      <= tick_c;
            line_start  <= v_en_c;
            frame_start <= v_en_c && v_tc_c;
            if (!run || tick_c) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (v_en_c && v_tc_c) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    always_comb begin
        raw_c    = SYNC_IDLE;
        raw_c.de = (x < X_ACT) && (y < Y_ACT);
        if (x >= HS_START && x < HS_END) begin
            raw_c.hs = HS_POL;
        end
        if (y >= VS_START && y < VS_END) begin
            raw_c.vs = VS_POL;
        end
    end

    // Stage 0 registers the decode; later stages step once per pixel so each adds one pixel of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= int'(PIPE_DLY); i++) begin
                pipe[i] <= SYNC_IDLE;
            end
        end else if (!run) begin
            for (int i = 0; i <= int'(PIPE_DLY); i++) begin
                pipe[i] <= SYNC_IDLE;
            end
        end else begin
            pipe[0] <= raw_c;
            if (pix_en) begin
                for (int i = 1; i <= int'(PIPE_DLY); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign de = pipe[PIPE_DLY].de;
    assign hs = pipe[PIPE_DLY].hs;
    assign vs = pipe[PIPE_DLY].vs;

endmodule
